cache_arbiter: RTL and testbench

Merges the instruction-cache and data-cache miss ports onto the single physical-memory line port, the counterpart of the line demultiplexer that steers returned 256-bit lines back to one of two destinations. It accepts one outstanding line request at a time, grants I or D by alternating priority on contention, and holds the address and write data stable until memory responds. It routes the response only to the granted client. It sits between the two L1 caches and the memory/cacheline adaptor.

---
 rtl/cache_arb_pkg.sv | 19 +
 rtl/cache_arbiter.sv | 144 ++++++++++++++
 tb/tb_cache_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cache miss arbiter.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    localparam int LINE_W = 256;

    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/cache_arbiter.sv
// Merges the I-cache and D-cache line miss ports onto one physical-memory
// line port. One request is outstanding at a time. Ties are broken by
// alternating priority. The memory-side request is held in registers for the
// whole transaction.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no transaction; requests are sampled, pmem_resp is ignored
//   SERVE_I | I-cache read in flight; the pmem_resp pulse goes to i_resp
//   SERVE_D | D-cache read/write in flight; the pmem_resp pulse goes to d_resp
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int width      = 256,
    parameter int addr_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_read,
    input  logic [addr_width-1:0] i_address,
    output logic [width-1:0]      i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [addr_width-1:0] d_address,
    input  logic [width-1:0]      d_wdata,
    output logic [width-1:0]      d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [addr_width-1:0] pmem_address,
    output logic [width-1:0]      pmem_wdata,
    input  logic [width-1:0]      pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_e            state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic [addr_width-1:0] pmem_address_q, pmem_address_d;
    logic [width-1:0]      pmem_wdata_q, pmem_wdata_d;

    logic                  i_pend;
    logic                  d_pend;
    logic                  sel_d;
    logic                  d_is_write;

    assign i_pend     = i_read;
    assign d_pend     = d_read | d_write;
    // A D request with both strobes high is treated as a write-back.
    assign d_is_write = d_write;

    // Next-state logic: arbitrate in IDLE, wait for pmem_resp while serving.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        sel_d          = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the client that did not win last time goes first.
                if (i_pend && d_pend) begin
                    sel_d = (last_grant_q == GRANT_I);
                end else begin
                    sel_d = d_pend;
                end

                if (i_pend || d_pend) begin
                    if (sel_d) begin
                        state_d        = SERVE_D;
                        last_grant_d   = GRANT_D;
                        pmem_address_d = d_address;
                        pmem_write_d   = d_is_write;
                        pmem_read_d    = ~d_is_write;
                        if (d_is_write) begin
                            pmem_wdata_d = d_wdata;
                        end
                    end else begin
                        state_d        = SERVE_I;
                        last_grant_d   = GRANT_I;
                        pmem_address_d = i_address;
                        pmem_write_d   = 1'b0;
                        pmem_read_d    = 1'b1;
                    end
                end
            end

            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end

            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    // State and memory-side request registers; reset returns to IDLE with I as last grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= GRANT_I;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

    // Read data fans out to both clients; only the completion pulse is steered.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // A pmem_resp that arrives in the same cycle as reset is dropped.
    assign i_resp = ~rst & pmem_resp & (state_q == SERVE_I);
    assign d_resp = ~rst & pmem_resp & (state_q == SERVE_D);

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected memory transactions are queued
// in grant order when requests are raised and checked as they appear on pmem.
module tb_cache_arbiter;
    import cache_arb_pkg::*;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [31:0]   i_address;
    logic [255:0]  i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [31:0]   d_address;
    logic [255:0]  d_wdata;
    logic [255:0]  d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [255:0]  pmem_wdata;
    logic [255:0]  pmem_rdata;
    logic          pmem_resp;

    cache_arbiter #(.width(256), .addr_width(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit is_d, input bit wr, input logic [31:0] addr,
                            input logic [255:0] wdata);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    // Wait for the next pmem strobe, check it against the scoreboard head,
    // hold it for `latency` cycles, answer with `rdata`, and check the steered pulse.
    task automatic serve_one(input int exp_wait, input int latency,
                             input logic [255:0] rdata, input bit poke);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (!(pmem_read || pmem_write) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!(pmem_read || pmem_write)) begin
            chk("strobe_timeout", 1'b0, 1'b1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 1'b1, 1'b0);
            return;
        end
        e = exp_q.pop_front();
        chk("strobe_latency", waited, exp_wait);
        chk("pmem_read", pmem_read, !e.wr);
        chk("pmem_write", pmem_write, e.wr);
        chk("pmem_address", pmem_address, e.addr);
        if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
        chk("early_resp", {i_resp, d_resp}, 2'b00);

        if (poke) begin
            d_address = 32'hDEAD_BEE0;
            i_address = 32'hCAFE_0000;
            d_wdata   = ~d_wdata;
        end

        for (int k = 0; k < latency; k++) begin
            @(negedge clk);
            chk("hold_read", pmem_read, !e.wr);
            chk("hold_write", pmem_write, e.wr);
            chk("hold_address", pmem_address, e.addr);
            if (e.wr) chk("hold_wdata", pmem_wdata, e.wdata);
            chk("hold_no_resp", {i_resp, d_resp}, 2'b00);
        end

        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        #1;
        chk("i_resp", i_resp, !e.is_d);
        chk("d_resp", d_resp, e.is_d);
        if (e.is_d) chk("d_rdata", d_rdata, rdata);
        else        chk("i_rdata", i_rdata, rdata);

        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        if (e.is_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        @(negedge clk);
        chk("post_resp_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("resp_one_cycle", {i_resp, d_resp}, 2'b00);
    endtask

    initial begin
        rst        = 1'b1;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_address", pmem_address, 32'h0);
        chk("rst_pmem_wdata", pmem_wdata, 256'h0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single I read.
        @(posedge clk);
        #1;
        i_address = 32'h0000_1000;
        i_read    = 1'b1;
        push_exp(1'b0, 1'b0, 32'h0000_1000, '0);
        serve_one(1, 3, {32{8'hA5}}, 1'b0);

        // D write-back with address/data disturbed mid-transaction.
        @(posedge clk);
        #1;
        d_address = 32'h0000_2040;
        d_wdata   = {32{8'h5A}};
        d_write   = 1'b1;
        push_exp(1'b1, 1'b1, 32'h0000_2040, {32{8'h5A}});
        serve_one(1, 3, {32{8'h11}}, 1'b1);

        // Reset, then a tie: D first, then I after one idle cycle.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        i_address = 32'h0000_4000;
        d_address = 32'h0000_3000;
        i_read    = 1'b1;
        d_read    = 1'b1;
        push_exp(1'b1, 1'b0, 32'h0000_3000, '0);
        push_exp(1'b0, 1'b0, 32'h0000_4000, '0);
        serve_one(1, 2, {32{8'h3C}}, 1'b0);
        serve_one(0, 1, {32{8'hC3}}, 1'b0);

        // Both re-raised: I was served last, so D wins again.
        @(posedge clk);
        #1;
        i_address = 32'h0000_4100;
        d_address = 32'h0000_3100;
        i_read    = 1'b1;
        d_read    = 1'b1;
        push_exp(1'b1, 1'b0, 32'h0000_3100, '0);
        push_exp(1'b0, 1'b0, 32'h0000_4100, '0);
        serve_one(1, 1, {32{8'h77}}, 1'b0);
        serve_one(0, 2, {32{8'h88}}, 1'b0);

        // d_read and d_write together behave as a write.
        @(posedge clk);
        #1;
        d_address = 32'h0000_7080;
        d_wdata   = {16{16'hBEEF}};
        d_read    = 1'b1;
        d_write   = 1'b1;
        push_exp(1'b1, 1'b1, 32'h0000_7080, {16{16'hBEEF}});
        serve_one(1, 2, {32{8'h99}}, 1'b0);

        // Reset during SERVE_D with a coincident pmem_resp.
        @(posedge clk);
        #1;
        d_address = 32'h0000_5000;
        d_read    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_case_strobe", pmem_read, 1'b1);
        pmem_rdata = {32{8'hEE}};
        rst        = 1'b1;
        pmem_resp  = 1'b1;
        #1;
        chk("rst_case_no_resp", {i_resp, d_resp}, 2'b00);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pmem_resp = 1'b0;
        d_read    = 1'b0;
        @(negedge clk);
        chk("rst_case_read", pmem_read, 1'b0);
        chk("rst_case_write", pmem_write, 1'b0);
        chk("rst_case_address", pmem_address, 32'h0);
        chk("rst_case_wdata", pmem_wdata, 256'h0);
        chk("rst_case_resp", {i_resp, d_resp}, 2'b00);

        // I request after the reset is served normally.
        @(posedge clk);
        #1;
        i_address = 32'h0000_6000;
        i_read    = 1'b1;
        push_exp(1'b0, 1'b0, 32'h0000_6000, '0);
        serve_one(1, 2, {32{8'h42}}, 1'b0);

        // Spurious pmem_resp while idle.
        pmem_rdata = {32{8'hF0}};
        pmem_resp  = 1'b1;
        #1;
        chk("spurious_no_resp", {i_resp, d_resp}, 2'b00);
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("spurious_idle_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("spurious_idle_resp", {i_resp, d_resp}, 2'b00);

        // A D read after the spurious pulse still starts from IDLE.
        @(posedge clk);
        #1;
        d_address = 32'h0000_8000;
        d_read    = 1'b1;
        push_exp(1'b1, 1'b0, 32'h0000_8000, '0);
        serve_one(1, 1, {32{8'h0F}}, 1'b0);

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
